uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 75 +++++++
 rtl/uart_tx_fifo.sv | 109 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: byte width and transmit-launch FSM encoding.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } tx_state_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO: storage array, wrapping pointers and registered full/empty/count flags.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic [CW-1:0]    count_next;

    // full/empty come from the registered state, so a pop cannot make room for a same-edge write
    assign push = wr_en && !full && !flush;
    assign pop  = rd_en && !empty && !flush;

    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count - CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count    <= count_next;
            full     <= (count_next == CNT_FULL);
            empty    <= (count_next == '0);
            overflow <= wr_en && full;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit queue in front of the UART: buffers host bytes and launches one frame at a time.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a queued byte and a quiet transmitter
// LAUNCH  | uart_start high for one cycle, uart_data holds the popped byte
// WAIT_HI | waiting up to BUSY_WAIT cycles for uart_busy to rise
// WAIT_LO | frame in progress, waiting for uart_busy to fall
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int BUSY_WAIT = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   flush,
    input  logic                   uart_busy,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   uart_start,
    output logic [DATA_W-1:0]      uart_data
);

    localparam int TW = $clog2(BUSY_WAIT + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(BUSY_WAIT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    tx_state_t         state;
    tx_state_t         state_next;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_next;
    logic              pop;
    logic [DATA_W-1:0] head;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always_comb begin
        state_next = state;
        timer_next = timer;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !uart_busy && !flush) begin
                    pop        = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = WAIT_HI;
                timer_next = TIMER_LOAD;
            end
            WAIT_HI: begin
                // a transmitter that never raises busy is assumed to have sent the byte
                if (uart_busy) begin
                    state_next = WAIT_LO;
                end else if (timer == '0) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer - TIMER_ONE;
                end
            end
            WAIT_LO: begin
                if (!uart_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            uart_data <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            if (pop) begin
                uart_data <= head;
            end
        end
    end

    assign uart_start = (state == LAUNCH);

endmodule
